// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the elastic buffers that sit between pipeline stages.
// Occupancy classification is kept here so every stage buffer decodes it identically.
package pipes;

    localparam int PIPE_BUF_MAX_DEPTH = 16;
    localparam int PIPE_BUF_CNT_W     = $clog2(PIPE_BUF_MAX_DEPTH + 1);

    typedef logic [PIPE_BUF_CNT_W-1:0] pipe_buf_cnt_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } pipe_buf_occ_e;

    function automatic pipe_buf_occ_e pipe_buf_occ(input pipe_buf_cnt_t cnt,
                                                   input pipe_buf_cnt_t depth);
        if (cnt == '0) begin
            return OCC_EMPTY;
        end
        if (cnt == depth) begin
            return OCC_FULL;
        end
        return OCC_PARTIAL;
    endfunction

endpackage

// File: rtl/pipe_buf_ptr.sv
// Modulo-DEPTH circular pointer: advances on inc, returns to 0 on clr.
// Wraps explicitly at DEPTH-1, so non-power-of-two depths behave correctly.
module pipe_buf_ptr #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] r_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (clr) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + PTR_W'(1);
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/pipe_stage_buf.sv
// DEPTH-entry elastic buffer between two pipeline stages with valid/ready handshake,
// redirect flush and a saturating stall counter. in_ready never depends on out_ready.
module pipe_stage_buf
    import pipes::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    if (DEPTH < 1 || DEPTH > PIPE_BUF_MAX_DEPTH) begin : g_bad_depth
        $error("pipe_stage_buf: DEPTH out of range");
    end

    // Sized to the pointer range so every pointer value indexes a real entry;
    // entries at or above DEPTH are never written.
    logic [WIDTH-1:0] r_mem [2**PTR_W];
    logic [CW-1:0]    r_count;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [PTR_W-1:0] w_wr_ptr;
    logic [PTR_W-1:0] w_rd_ptr;
    logic             w_push;
    logic             w_pop;
    pipe_buf_occ_e    w_occ;

    assign w_occ     = pipe_buf_occ(pipe_buf_cnt_t'(r_count), pipe_buf_cnt_t'(DEPTH));
    assign in_ready  = (w_occ != OCC_FULL);
    assign out_valid = (w_occ != OCC_EMPTY);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    pipe_buf_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (w_push),
        .clr   (flush),
        .ptr   (w_wr_ptr)
    );

    pipe_buf_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (w_pop),
        .clr   (flush),
        .ptr   (w_rd_ptr)
    );

    // NOTE: payload storage has no reset; out_valid already qualifies its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            r_count <= r_count - CW'(1);
        end
    end

    // Performance counter survives flush; it saturates instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && !flush && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign out_data  = r_mem[w_rd_ptr];
    assign count     = r_count;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: three instances (DEPTH 2, 3 with a 4-bit
// stall counter, and 1); stimulus queues expected words, per-instance monitors check them.
module tb_pipe_stage_buf;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: DEPTH=2
    logic       a_flush = 0, a_in_valid = 0, a_out_ready = 0;
    logic [7:0] a_in_data = '0;
    logic       a_in_ready, a_out_valid;
    logic [7:0] a_out_data;
    logic [1:0] a_count;
    logic [31:0] a_stall;
    // Instance B: DEPTH=3, CNT_W=4
    logic       b_flush = 0, b_in_valid = 0, b_out_ready = 0;
    logic [7:0] b_in_data = '0;
    logic       b_in_ready, b_out_valid;
    logic [7:0] b_out_data;
    logic [1:0] b_count;
    logic [3:0] b_stall;
    // Instance C: DEPTH=1
    logic       c_flush = 0, c_in_valid = 0, c_out_ready = 0;
    logic [7:0] c_in_data = '0;
    logic       c_in_ready, c_out_valid;
    logic [7:0] c_out_data;
    logic [0:0] c_count;
    logic [31:0] c_stall;

    exp_t a_q[$], b_q[$], c_q[$];
    int   a_deliv = 0, b_deliv = 0, c_deliv = 0;

    pipe_stage_buf #(.WIDTH(8), .DEPTH(2), .CNT_W(32)) u_a (
        .clk(clk), .reset(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .count(a_count), .stall_cnt(a_stall));

    pipe_stage_buf #(.WIDTH(8), .DEPTH(3), .CNT_W(4)) u_b (
        .clk(clk), .reset(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .count(b_count), .stall_cnt(b_stall));

    pipe_stage_buf #(.WIDTH(8), .DEPTH(1), .CNT_W(32)) u_c (
        .clk(clk), .reset(rst), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .count(c_count), .stall_cnt(c_stall));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitors: a transfer is a valid head with ready high and no flush.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && a_out_valid && a_out_ready && !a_flush) begin
            a_deliv++;
            if (a_q.size() == 0) begin
                check("a_unexpected_word", 64'(a_out_data), 64'hx_dead);
            end else begin
                e = a_q.pop_front();
                check("a_data", 64'(a_out_data), 64'(e.data));
                if (e.due >= 0) check("a_latency_cycle", 64'(cyc), 64'(e.due));
            end
        end
        if (!rst && b_out_valid && b_out_ready && !b_flush) begin
            b_deliv++;
            if (b_q.size() == 0) begin
                check("b_unexpected_word", 64'(b_out_data), 64'hx_dead);
            end else begin
                e = b_q.pop_front();
                check("b_data", 64'(b_out_data), 64'(e.data));
                if (e.due >= 0) check("b_latency_cycle", 64'(cyc), 64'(e.due));
            end
        end
        if (!rst && c_out_valid && c_out_ready && !c_flush) begin
            c_deliv++;
            if (c_q.size() == 0) begin
                check("c_unexpected_word", 64'(c_out_data), 64'hx_dead);
            end else begin
                e = c_q.pop_front();
                check("c_data", 64'(c_out_data), 64'(e.data));
                if (e.due >= 0) check("c_latency_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       take;
        int         w;

        cycles(3);
        rst = 1'b0;

        // Reset / idle state on every instance
        check("a_rst_count", 64'(a_count), 0);
        check("a_rst_out_valid", 64'(a_out_valid), 0);
        check("a_rst_in_ready", 64'(a_in_ready), 1);
        check("a_rst_stall", 64'(a_stall), 0);
        check("b_rst_count", 64'(b_count), 0);
        check("b_rst_out_valid", 64'(b_out_valid), 0);
        check("b_rst_in_ready", 64'(b_in_ready), 1);
        check("b_rst_stall", 64'(b_stall), 0);
        check("c_rst_count", 64'(c_count), 0);
        check("c_rst_in_ready", 64'(c_in_ready), 1);

        // A: streaming 0x11, 0x22, 0x33 with 1-cycle latency and in_ready held high
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in_data = 8'(8'h11 * (i + 1));
            check("a_in_ready_stream", 64'(a_in_ready), 1);
            cycles(1);
            a_q.push_back('{a_in_data, cyc});
        end
        a_in_valid = 1'b0;
        check("a_in_ready_after", 64'(a_in_ready), 1);
        cycles(3);
        check("a_drained_count", 64'(a_count), 0);
        check("a_delivered", 64'(a_deliv), 3);
        check("a_queue_left", 64'(a_q.size()), 0);

        // C: DEPTH=1 alternates in_ready and delivers one word every two cycles
        c_out_ready = 1'b1;
        c_in_valid  = 1'b1;
        d = 8'h51;
        for (int i = 0; i < 8; i++) begin
            check("c_in_ready_alt", 64'(c_in_ready), 64'((i % 2) == 0));
            take      = c_in_ready;
            c_in_data = d;
            cycles(1);
            if (take) begin
                c_q.push_back('{d, cyc});
                d = d + 8'd1;
            end
        end
        c_in_valid = 1'b0;
        cycles(3);
        check("c_delivered", 64'(c_deliv), 4);
        check("c_drained_count", 64'(c_count), 0);

        // B: fill DEPTH=3 with out_ready low, hold 0xA3 upstream, saturate stall_cnt
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            b_in_data = 8'(8'hA0 + k);
            cycles(1);
            b_q.push_back('{b_in_data, -1});
            check("b_stall_fill", 64'(b_stall), 64'(k));
        end
        check("b_full_count", 64'(b_count), 3);
        check("b_full_in_ready", 64'(b_in_ready), 0);
        b_in_data = 8'hA3;
        for (int k = 3; k < 22; k++) begin
            cycles(1);
            check("b_stall_sat", 64'(b_stall), 64'((k < 15) ? k : 15));
            if (k == 4) begin
                check("b_hold_in_ready", 64'(b_in_ready), 0);
                check("b_hold_count", 64'(b_count), 3);
            end
        end
        b_out_ready = 1'b1;
        w = 0;
        while (!b_in_ready && w < 8) begin
            cycles(1);
            w++;
        end
        check("b_ready_timeout", 64'(b_in_ready), 1);
        cycles(1);
        b_q.push_back('{8'hA3, -1});
        b_in_valid = 1'b0;
        cycles(5);
        check("b_drained_count", 64'(b_count), 0);
        check("b_delivered_wrap", 64'(b_deliv), 4);
        check("b_stall_held", 64'(b_stall), 15);

        // B: flush with count=2 while a new word and a ready consumer are present
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            b_in_data = 8'(8'hB0 + k);
            cycles(1);
            b_q.push_back('{b_in_data, -1});
        end
        check("b_pre_flush_count", 64'(b_count), 2);
        b_in_data   = 8'hEE;
        b_flush     = 1'b1;
        b_out_ready = 1'b1;
        cycles(1);
        b_flush    = 1'b0;
        b_in_valid = 1'b0;
        b_q.delete();
        check("b_flush_count", 64'(b_count), 0);
        check("b_flush_out_valid", 64'(b_out_valid), 0);
        check("b_flush_in_ready", 64'(b_in_ready), 1);
        check("b_flush_stall_kept", 64'(b_stall), 15);
        b_in_valid = 1'b1;
        b_in_data  = 8'hC0;
        cycles(1);
        b_q.push_back('{8'hC0, cyc});
        b_in_valid = 1'b0;
        cycles(3);
        check("b_post_flush_delivered", 64'(b_deliv), 5);
        check("b_post_flush_queue", 64'(b_q.size()), 0);

        // B: asynchronous reset mid-cycle with entries held
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            b_in_data = 8'(8'hD0 + k);
            cycles(1);
            b_q.push_back('{b_in_data, -1});
        end
        b_in_valid = 1'b0;
        check("b_pre_reset_count", 64'(b_count), 2);
        @(negedge clk);
        #2;
        rst = 1'b1;
        b_q.delete();
        #1;
        check("b_async_count", 64'(b_count), 0);
        check("b_async_out_valid", 64'(b_out_valid), 0);
        check("b_async_in_ready", 64'(b_in_ready), 1);
        check("b_async_stall", 64'(b_stall), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_data   = 8'hE5;
        cycles(1);
        b_q.push_back('{8'hE5, cyc});
        b_in_valid = 1'b0;
        check("b_first_push_count", 64'(b_count), 1);
        cycles(3);
        check("b_final_delivered", 64'(b_deliv), 6);
        check("b_final_queue", 64'(b_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic buffer placed between two CPU pipeline stages (fetch→decode, decode→execute, …), carrying one packed stage record (`fetch_data_t`, `decode_data_t`, …) per entry. It replaces the fixed single-register stage latch with a DEPTH-entry circular buffer using a valid/ready handshake. It supports a flush for branch/jump redirect and keeps a saturating stall counter for performance analysis. All outputs are registered, so no combinational path exists from the input side to the output side.

## Interface
- `WIDTH`, 64: payload width in bits; set to `$bits(<stage>_data_t)` at instantiation.
- `DEPTH`, 2: number of entries, legal range 1..16. DEPTH≥2 is required for one transfer per cycle.
- `CNT_W`, 32: width of the stall counter.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  discards all entries and the same-cycle input.
- `in_valid`  in  1  upstream presents `in_data`.
- `in_ready`  out  1  buffer can accept this cycle.
- `in_data`  in  WIDTH  payload.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  downstream consumes the head this cycle.
- `out_data`  out  WIDTH  head payload.
- `count`  out  $clog2(DEPTH+1)  occupied entries.
- `stall_cnt`  out  CNT_W  cycles with `out_valid && !out_ready`, saturating.

## Operation
- push = `in_valid && in_ready && !flush`.
- pop = `out_valid && out_ready && !flush`.
- `in_ready` = (`count` != DEPTH). It depends only on registered state, never on `out_ready`. A full buffer therefore cannot push and pop in the same cycle.
- Entries live in a DEPTH-entry array.
  - `wr_ptr` advances on push, `rd_ptr` advances on pop.
  - Both pointers wrap from DEPTH-1 to 0, including for DEPTH values that are not a power of 2.
- `out_data` = `mem[rd_ptr]`. `out_valid` = (`count` != 0).
- Occupancy state, encoded as `count`:
  - EMPTY: `count`=0.
  - PARTIAL: 0<`count`<DEPTH.
  - FULL: `count`=DEPTH.
- Transitions:
  - push only: `count`+1.
  - pop only: `count`−1.
  - push and pop together: `count` unchanged; data moves in FIFO order.
  - flush: `count`←0 and `rd_ptr`←`wr_ptr`←0, whatever the other inputs are.
- Flush has priority over push and pop. An entry presented with `flush` high is not stored. A head presented with `flush` high counts as not consumed. Downstream must ignore `out_valid` in the flush cycle.
- `stall_cnt` increments when `out_valid && !out_ready && !flush`. It holds at 2^CNT_W−1 once there, and is not cleared by `flush`.
- Array contents are not reset. Only pointers, `count` and `stall_cnt` are reset.

## Timing
- Reset values (asynchronous, immediate): `count`=0, `out_valid`=0, `in_ready`=1, `stall_cnt`=0, pointers=0. `out_data` is don't-care while `out_valid`=0.
- Latency: data pushed at edge N is visible on `out_data` with `out_valid`=1 after edge N. Minimum latency is 1 cycle; there is no bypass.
- Throughput:
  - DEPTH≥2: one transfer per cycle in steady state.
  - DEPTH=1: one transfer every 2 cycles, because a full buffer cannot accept.
- Reset asserted mid-operation: all occupancy is lost immediately. After reset is released, the first push takes effect on the next rising edge.

## Structure
- Package `pipes` gains:
  - `PIPE_BUF_MAX_DEPTH = 16`.
  - Helper typedef `pipe_buf_cnt_t`, sized for the maximum depth.
- Sub-module `pipe_buf_ptr`: a modulo-DEPTH pointer with `inc` and `clr` inputs. It is instantiated twice, for read and write.
- Per-stage instances are created in the core top. The flush source is the execute-stage redirect.

## Test plan
- Reset, then idle: `count`=0, `out_valid`=0, `in_ready`=1, `stall_cnt`=0.
- DEPTH=2, `out_ready`=1, push 0x11, 0x22, 0x33 on consecutive cycles → each word appears exactly 1 cycle after its push, in order. `in_ready` stays 1 throughout.
- DEPTH=3, `out_ready`=0, push 4 words 0xA0..0xA3 → `count` reaches 3 and `in_ready` goes 0. 0xA3 is held upstream. `stall_cnt` increments every cycle with `out_valid`=1. Then set `out_ready`=1 → 0xA0, 0xA1, 0xA2, 0xA3 come out in order; the pointers wrap 2→0.
- `count`=2, then pulse `flush` while `in_valid`=1 and `out_ready`=1 → next cycle `count`=0 and `out_valid`=0. The flushed-cycle input does not appear afterwards. `stall_cnt` keeps its value.
- DEPTH=1 streaming with `out_ready`=1 → `in_ready` alternates 1/0 and exactly one word is delivered every 2 cycles.
- CNT_W=4, `out_ready`=0 for 20 cycles with a valid head → `stall_cnt` saturates at 15 and holds. Assert `reset` asynchronously mid-cycle → all outputs return to their reset values before the next edge.
